// File: rtl/feedback_memory_mc.sv
// Per-channel two-tap operator feedback store with counter-driven clear sweep.
// Optional macro FBMEM_FWD_EN: same-cycle write-to-read forwarding on a matching channel.
module feedback_memory_mc #(
    parameter  int unsigned NUM_CH = 9,
    parameter  int unsigned DATA_W = 10,
    parameter  int unsigned AVG    = 1,
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              wr,
    input  logic [CH_W-1:0]   waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd,
    input  logic [CH_W-1:0]   raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              init_busy
);

    localparam logic [CH_W:0]   NUM_CH_L = (CH_W+1)'(NUM_CH);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

    logic [CH_W-1:0]          cnt;
    logic [DATA_W-1:0]        cur_tap  [NUM_CH];
    logic [DATA_W-1:0]        prev_tap [NUM_CH];

    logic                     wr_ok;
    logic                     rd_ok;
    logic [CH_W-1:0]          rd_idx;
    logic [DATA_W-1:0]        rd_cur;
    logic [DATA_W-1:0]        rd_prev;
    logic signed [DATA_W:0]   sum;
    logic [DATA_W-1:0]        rd_val_c;

    // Access qualification and read-side datapath (mean of taps or newest tap)
    always_comb begin
        wr_ok   = wr && !init_busy && ({1'b0, waddr} < NUM_CH_L);
        rd_ok   = !init_busy && ({1'b0, raddr} < NUM_CH_L);
        rd_idx  = rd_ok ? raddr : '0;
        rd_cur  = cur_tap[rd_idx];
        rd_prev = prev_tap[rd_idx];
`ifdef FBMEM_FWD_EN
        // Accepted write to the channel being read: newest tap comes from wdata
        if (wr_ok && rd_ok && (raddr == waddr)) begin
            rd_cur  = wdata;
            rd_prev = cur_tap[rd_idx];
        end
`endif
        sum      = $signed({rd_cur[DATA_W-1], rd_cur}) + $signed({rd_prev[DATA_W-1], rd_prev});
        rd_val_c = (AVG != 0) ? DATA_W'(sum >>> 1) : rd_cur;
    end

    // Sweep counter, busy flag and registered read port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            init_busy <= 1'b1;
            rdata     <= '0;
            rvalid    <= 1'b0;
        end else begin
            rvalid <= rd;
            if (rd) begin
                rdata <= rd_ok ? rd_val_c : '0;
            end
            if (clr) begin
                cnt       <= '0;
                init_busy <= 1'b1;
            end else if (init_busy) begin
                if (cnt == LAST_CH) begin
                    init_busy <= 1'b0;
                end else begin
                    cnt <= cnt + CH_W'(1);
                end
            end
        end
    end

    // Tap storage: sweep clears one channel per cycle, otherwise shift in new sample
    always_ff @(posedge clk) begin
        if (init_busy) begin
            cur_tap[cnt]  <= '0;
            prev_tap[cnt] <= '0;
        end else if (wr_ok) begin
            prev_tap[waddr] <= cur_tap[waddr];
            cur_tap[waddr]  <= wdata;
        end
    end

endmodule
